// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM states, default operand width and multiplier latency for the RSA core.
package rsa_pkg;
  localparam int BITWIDTH = 256;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MONT, S_CALC, S_DONE} state_t;
  function automatic int mm_latency(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: bit-serial Montgomery multiplier, o_r = x*y*2^-W mod n, done W+1 cycles after start.
module rsa_mont_mul import rsa_pkg::*; #(
  parameter int BITWIDTH = rsa_pkg::BITWIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [BITWIDTH-1:0] i_x,
  input  logic [BITWIDTH-1:0] i_y,
  input  logic [BITWIDTH-1:0] i_n,
  output logic [BITWIDTH-1:0] o_r,
  output logic                o_done
);
  localparam int CW = $clog2(BITWIDTH + 1);
  logic                busy;
  logic [CW-1:0]       cnt;
  logic [BITWIDTH-1:0] x_q, y_q, n_q;
  logic [BITWIDTH+1:0] r, r1, r2, r_nx, xs, ns;
  logic                yb;
  // The first iteration runs on the start edge from the live inputs, so the
  // correction (final cycle) coincides with the done pulse.
  always_comb begin
    xs   = {2'b0, busy ? x_q : i_x};
    ns   = {2'b0, busy ? n_q : i_n};
    yb   = busy ? y_q[0] : i_y[0];
    r1   = (busy ? r : '0) + (yb ? xs : '0);
    r2   = r1 + (r1[0] ? ns : '0);
    r_nx = r2 >> 1;
  end
  assign o_done = busy && (cnt == CW'(mm_latency(BITWIDTH) - 1));
  assign o_r    = BITWIDTH'(r >= {2'b0, n_q} ? r - {2'b0, n_q} : r);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      n_q  <= '0;
      r    <= '0;
    end else if (!busy) begin
      if (i_start) begin
        busy <= 1'b1;
        cnt  <= CW'(1);
        x_q  <= i_x;
        y_q  <= i_y >> 1;
        n_q  <= i_n;
        r    <= r_nx;
      end
    end else if (o_done) begin
      busy <= 1'b0;
    end else begin
      r   <= r_nx;
      y_q <= y_q >> 1;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: a^d mod n by Montgomery pre-scaling and right-to-left square-and-multiply.
module rsa_modexp_core import rsa_pkg::*; #(
  parameter int BITWIDTH = rsa_pkg::BITWIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [BITWIDTH-1:0] i_a,
  input  logic [BITWIDTH-1:0] i_d,
  input  logic [BITWIDTH-1:0] i_n,
  output logic [BITWIDTH-1:0] o_a_pow_d,
  output logic                o_finished
);
  localparam int CW = $clog2(BITWIDTH);
  state_t              state, state_nx;
  logic [BITWIDTH-1:0] d_q, n_q, t, m, ma, mb;
  logic [CW-1:0]       cnt, bidx;
  logic [BITWIDTH:0]   t2;
  logic                ma_done, mb_done, mm_start;
  assign t2       = {t, 1'b0};
  assign mm_start = (state == S_MONT);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = i_start ? S_PREP : S_IDLE;
      S_PREP:  state_nx = (cnt == CW'(BITWIDTH - 1)) ? S_MONT : S_PREP;
      S_MONT:  state_nx = (ma_done && mb_done) ? S_CALC : S_MONT;
      S_CALC:  state_nx = (bidx == CW'(BITWIDTH - 1)) ? S_DONE : S_MONT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // m stays in the normal domain while t carries a^(2^i) * 2^W mod n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      d_q        <= '0;
      n_q        <= '0;
      t          <= '0;
      m          <= '0;
      cnt        <= '0;
      bidx       <= '0;
      o_a_pow_d  <= '0;
      o_finished <= 1'b0;
    end else begin
      state      <= state_nx;
      o_finished <= (state == S_DONE);
      case (state)
        S_IDLE: if (i_start) begin
          d_q  <= i_d;
          n_q  <= i_n;
          t    <= i_a;
          m    <= BITWIDTH'(1);
          cnt  <= '0;
          bidx <= '0;
        end
        S_PREP: begin
          t   <= (t2 >= {1'b0, n_q}) ? BITWIDTH'(t2 - {1'b0, n_q}) : t2[BITWIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
        S_CALC: begin
          m    <= d_q[bidx] ? ma : m;
          t    <= mb;
          bidx <= bidx + 1'b1;
        end
        S_DONE:  o_a_pow_d <= m;
        default: ;
      endcase
    end
  end
  rsa_mont_mul #(.BITWIDTH(BITWIDTH)) u_ma (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(mm_start),
    .i_x(m), .i_y(t), .i_n(n_q), .o_r(ma), .o_done(ma_done)
  );
  rsa_mont_mul #(.BITWIDTH(BITWIDTH)) u_mb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(mm_start),
    .i_x(t), .i_y(t), .i_n(n_q), .o_r(mb), .o_done(mb_done)
  );
endmodule
